matrix_seq: RTL and testbench
=============================

Name: matrix_seq

Overview:
Sequencer on the driving side of the adjacency-matrix element array. It accepts edge-insert and edge-query transactions and resolves vertex IDs to element slots by broadcast compare. It allocates new slots on first sight of a vertex, drives the element strobes, and reduces the element outputs into a single query result. It sits between the edge-stream front end and the WINSIZE-element matrix.

Parameters:
WINSIZE, 200, number of matrix elements (vertex slots)
ID_WIDTH, 11, vertex ID width
ADDR_W, $clog2(WINSIZE), slot index width (derived, not overridden)

Ports:
clk  in  1  clock; all state on posedge
rst_n  in  1  async active-low reset; element array reset is driven from !rst_n at top level
edge_valid  in  1  insert request
edge_src  in  ID_WIDTH  insert source vertex ID
edge_dst  in  ID_WIDTH  insert destination vertex ID
edge_ready  out  1  insert accepted when valid&ready
qry_valid  in  1  query request
qry_src  in  ID_WIDTH  query source ID
qry_dst  in  ID_WIDTH  query destination ID
qry_ready  out  1  query accepted when valid&ready
result_valid  out  1  one-cycle pulse, query done
result_edge  out  1  edge src->dst present; valid with result_valid
edge_in  out  ID_WIDTH  broadcast ID to all elements
data_rdy_in  out  WINSIZE  one-hot slot-init strobe
edge_rdy  out  1  row-write strobe to elements
edge_addr  out  ADDR_W  row (destination slot) index
is_equal_vec  in  WINSIZE  per-element compare hit
has_edge_vec  in  WINSIZE  per-element row-bit hit
fill_cnt  out  ADDR_W+1  slots allocated
overflow  out  1  sticky: vertex dropped, window full
multi_hit  out  1  sticky: >1 is_equal bit set

Behaviour:
- Reset: state IDLE; all outputs 0; fill_cnt 0; overflow/multi_hit 0. Reset mid-transaction abandons it with no result pulse.
- Elements register on negedge, so compare results are sampled one posedge after edge_in changes. edge_in holds its value until the state that samples it.
- edge_ready=1 only in IDLE. qry_ready=1 only in IDLE with edge_valid=0. Insert wins a simultaneous request.
- Slot lookup (LOOK_x, then RES_x): LOOK drives edge_in=ID. RES samples is_equal_vec.
  - Hit: slot = lowest set index. If more than one bit is set, also set multi_hit.
  - Miss on insert with fill_cnt<WINSIZE: pulse data_rdy_in[fill_cnt] for one cycle with edge_in held; slot = fill_cnt; fill_cnt++.
  - Miss on insert with fill_cnt==WINSIZE: set overflow, drop the edge, go to IDLE.
- Insert FSM: IDLE -> LOOK_DST -> RES_DST (dst_slot) -> LOOK_SRC -> RES_SRC -> WRITE -> IDLE.
  - WRITE: edge_in=src, edge_addr=dst_slot, edge_rdy=1 for exactly one cycle.
  - src==dst: the dst allocation is visible at the src lookup, so it hits the same slot (self-loop).
  - Latency: accept to return to IDLE = 6 cycles. A miss adds no cycle.
- Query FSM: IDLE -> Q_LOOK_DST -> Q_RES_DST -> Q_LOOK_SRC -> Q_RES_SRC -> Q_READ -> Q_SAMPLE -> IDLE.
  - Queries never allocate. A miss on either ID goes straight to a result pulse with result_edge=0.
  - Q_READ: edge_in=src, edge_addr=dst_slot. Q_SAMPLE: result_edge = |has_edge_vec; result_valid=1.
- edge_rdy, data_rdy_in and result_valid are 0 in every state not listed above.
- edge_addr holds its last value when unused.
- fill_cnt saturates at WINSIZE; there is no wrap or slot eviction.

Optional Feature:
MATRIX_SEQ_DEDUP_EN:
- Defined: an insert takes the query read path (READ, SAMPLE) before WRITE, adding 2 cycles.
  - Edge already present: skip edge_rdy and increment output dup_cnt (16 bits, saturating, reset 0).
- Undefined: no dup_cnt port; every insert writes; insert latency is 6 cycles.

Test Plan:
- Reset, then insert (5,9) -> data_rdy_in[0] pulse with edge_in=9, then data_rdy_in[1] with edge_in=5; edge_rdy with edge_addr=0, edge_in=5; fill_cnt=2.
- Query (5,9) after the above -> result_valid with result_edge=1. Query (9,5) -> result_edge=0. Query (5,7) -> result_edge=0 and no data_rdy_in pulse.
- WINSIZE=4: insert 4 distinct vertices, then (1,100) with 100 new -> overflow=1, no edge_rdy, fill_cnt=4.
- edge_valid and qry_valid high in the same cycle -> edge_ready=1, qry_ready=0. The query is accepted when the FSM is back in IDLE.
- Force is_equal_vec=4'b0110 in RES -> slot 1 used, multi_hit=1.
- DEDUP_EN: insert (5,9) twice -> single edge_rdy, dup_cnt=1. rst_n low mid-WRITE -> outputs 0 immediately, FSM in IDLE.

Source files
------------

// File: rtl/matrix_seq.sv
// Insert/query sequencer for the adjacency-matrix element array: resolves vertex IDs to slots,
// allocates new slots, strobes row writes and reduces row hits. Optional MATRIX_SEQ_DEDUP_EN.
module matrix_seq #(
    parameter  int WINSIZE  = 200,
    parameter  int ID_WIDTH = 11,
    localparam int ADDR_W   = $clog2(WINSIZE)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                edge_valid,
    input  logic [ID_WIDTH-1:0] edge_src,
    input  logic [ID_WIDTH-1:0] edge_dst,
    output logic                edge_ready,
    input  logic                qry_valid,
    input  logic [ID_WIDTH-1:0] qry_src,
    input  logic [ID_WIDTH-1:0] qry_dst,
    output logic                qry_ready,
    output logic                result_valid,
    output logic                result_edge,
    output logic [ID_WIDTH-1:0] edge_in,
    output logic [WINSIZE-1:0]  data_rdy_in,
    output logic                edge_rdy,
    output logic [ADDR_W-1:0]   edge_addr,
    input  logic [WINSIZE-1:0]  is_equal_vec,
    input  logic [WINSIZE-1:0]  has_edge_vec,
`ifdef MATRIX_SEQ_DEDUP_EN
    output logic [15:0]         dup_cnt,
`endif
    output logic [ADDR_W:0]     fill_cnt,
    output logic                overflow,
    output logic                multi_hit
);

    // Handshakes: a request is taken on the posedge where valid and ready are both high;
    // ready depends only on FSM state (and edge_valid for queries), never on the
    // request payload, and the payload need not be held after that edge.

    typedef enum logic [3:0] {
        IDLE, LOOK_DST, RES_DST, LOOK_SRC, RES_SRC, WRITE,
        Q_LOOK_DST, Q_RES_DST, Q_LOOK_SRC, Q_RES_SRC, Q_READ, Q_SAMPLE,
        D_READ, D_SAMPLE
    } state_t;

    state_t              state, next_state;
    logic [ID_WIDTH-1:0] src_id, dst_id;
    logic [ADDR_W-1:0]   dst_slot, hit_idx, res_slot;
    logic                q_miss;
    logic                hit, multi, full;
    logic                alloc, set_ovf, set_mh, ld_dst, ld_addr, q_miss_set;
`ifdef MATRIX_SEQ_DEDUP_EN
    logic                dup_inc;
`endif

    assign hit      = |is_equal_vec;
    assign multi    = |(is_equal_vec & (is_equal_vec - WINSIZE'(1)));
    assign full     = (fill_cnt == (ADDR_W+1)'(WINSIZE));
    assign res_slot = hit ? hit_idx : fill_cnt[ADDR_W-1:0];

    assign edge_ready = rst_n && (state == IDLE);
    assign qry_ready  = edge_ready && !edge_valid;

    // Lowest set index wins when several elements claim the same ID.
    always_comb begin
        hit_idx = '0;
        for (int i = WINSIZE - 1; i >= 0; i--)
            if (is_equal_vec[i]) hit_idx = ADDR_W'(i);
    end

    always_comb begin
        next_state   = state;
        edge_in      = '0;
        data_rdy_in  = '0;
        edge_rdy     = 1'b0;
        result_valid = 1'b0;
        result_edge  = 1'b0;
        alloc        = 1'b0;
        set_ovf      = 1'b0;
        set_mh       = 1'b0;
        ld_dst       = 1'b0;
        ld_addr      = 1'b0;
        q_miss_set   = 1'b0;
`ifdef MATRIX_SEQ_DEDUP_EN
        dup_inc      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (edge_valid)     next_state = LOOK_DST;
                else if (qry_valid) next_state = Q_LOOK_DST;
            end
            LOOK_DST: begin edge_in = dst_id; next_state = RES_DST; end
            RES_DST: begin
                edge_in = dst_id;
                set_mh  = hit && multi;
                if (hit) begin
                    ld_dst     = 1'b1;
                    next_state = LOOK_SRC;
                end else if (!full) begin
                    data_rdy_in = WINSIZE'(1) << fill_cnt;
                    alloc       = 1'b1;
                    ld_dst      = 1'b1;
                    next_state  = LOOK_SRC;
                end else begin
                    set_ovf    = 1'b1;
                    next_state = IDLE;
                end
            end
            LOOK_SRC: begin edge_in = src_id; next_state = RES_SRC; end
            RES_SRC: begin
                edge_in = src_id;
                set_mh  = hit && multi;
                if (hit || !full) begin
                    if (!hit) begin
                        data_rdy_in = WINSIZE'(1) << fill_cnt;
                        alloc       = 1'b1;
                    end
                    ld_addr = 1'b1;
`ifdef MATRIX_SEQ_DEDUP_EN
                    next_state = D_READ;
`else
                    next_state = WRITE;
`endif
                end else begin
                    set_ovf    = 1'b1;
                    next_state = IDLE;
                end
            end
            WRITE: begin edge_in = src_id; edge_rdy = 1'b1; next_state = IDLE; end
`ifdef MATRIX_SEQ_DEDUP_EN
            D_READ: begin edge_in = src_id; next_state = D_SAMPLE; end
            D_SAMPLE: begin
                edge_in = src_id;
                if (|has_edge_vec) begin
                    dup_inc    = 1'b1;
                    next_state = IDLE;
                end else begin
                    next_state = WRITE;
                end
            end
`endif
            Q_LOOK_DST: begin edge_in = dst_id; next_state = Q_RES_DST; end
            Q_RES_DST: begin
                edge_in = dst_id;
                set_mh  = hit && multi;
                if (hit) begin
                    ld_dst     = 1'b1;
                    next_state = Q_LOOK_SRC;
                end else begin
                    q_miss_set = 1'b1;
                    next_state = Q_SAMPLE;
                end
            end
            Q_LOOK_SRC: begin edge_in = src_id; next_state = Q_RES_SRC; end
            Q_RES_SRC: begin
                edge_in = src_id;
                set_mh  = hit && multi;
                if (hit) begin
                    ld_addr    = 1'b1;
                    next_state = Q_READ;
                end else begin
                    q_miss_set = 1'b1;
                    next_state = Q_SAMPLE;
                end
            end
            Q_READ: begin edge_in = src_id; next_state = Q_SAMPLE; end
            Q_SAMPLE: begin
                edge_in      = src_id;
                result_valid = 1'b1;
                result_edge  = !q_miss && (|has_edge_vec);
                next_state   = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            src_id    <= '0;
            dst_id    <= '0;
            dst_slot  <= '0;
            edge_addr <= '0;
            fill_cnt  <= '0;
            overflow  <= 1'b0;
            multi_hit <= 1'b0;
            q_miss    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                q_miss <= 1'b0;
                if (edge_valid) begin
                    src_id <= edge_src;
                    dst_id <= edge_dst;
                end else if (qry_valid) begin
                    src_id <= qry_src;
                    dst_id <= qry_dst;
                end
            end
            if (q_miss_set) q_miss    <= 1'b1;
            if (ld_dst)     dst_slot  <= res_slot;
            if (ld_addr)    edge_addr <= dst_slot;
            if (alloc)      fill_cnt  <= fill_cnt + (ADDR_W+1)'(1);
            if (set_ovf)    overflow  <= 1'b1;
            if (set_mh)     multi_hit <= 1'b1;
        end
    end

`ifdef MATRIX_SEQ_DEDUP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         dup_cnt <= '0;
        else if (dup_inc && dup_cnt != '1)  dup_cnt <= dup_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_matrix_seq.sv
// Table-driven bench for matrix_seq (WINSIZE=4) with a behavioural element-array model;
// extra checks when MATRIX_SEQ_DEDUP_EN is defined.
module tb_matrix_seq;
    localparam int WS  = 4;
    localparam int IDW = 11;
    localparam int AW  = 2;
`ifdef MATRIX_SEQ_DEDUP_EN
    localparam int DX = 2;
`else
    localparam int DX = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           edge_valid = 1'b0, qry_valid = 1'b0;
    logic [IDW-1:0] edge_src = '0, edge_dst = '0, qry_src = '0, qry_dst = '0;
    logic           edge_ready, qry_ready, result_valid, result_edge, edge_rdy;
    logic [IDW-1:0] edge_in;
    logic [WS-1:0]  data_rdy_in, is_equal_vec, has_edge_vec;
    logic [AW-1:0]  edge_addr;
    logic [AW:0]    fill_cnt;
    logic           overflow, multi_hit;
`ifdef MATRIX_SEQ_DEDUP_EN
    logic [15:0]    dup_cnt;
`endif

    matrix_seq #(.WINSIZE(WS), .ID_WIDTH(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .edge_valid(edge_valid), .edge_src(edge_src), .edge_dst(edge_dst), .edge_ready(edge_ready),
        .qry_valid(qry_valid), .qry_src(qry_src), .qry_dst(qry_dst), .qry_ready(qry_ready),
        .result_valid(result_valid), .result_edge(result_edge),
        .edge_in(edge_in), .data_rdy_in(data_rdy_in), .edge_rdy(edge_rdy), .edge_addr(edge_addr),
        .is_equal_vec(is_equal_vec), .has_edge_vec(has_edge_vec),
`ifdef MATRIX_SEQ_DEDUP_EN
        .dup_cnt(dup_cnt),
`endif
        .fill_cnt(fill_cnt), .overflow(overflow), .multi_hit(multi_hit)
    );

    // clock / reset
    always #5 clk = ~clk;

    // element array model: registers on negedge, cleared by !rst_n
    logic [IDW-1:0] el_id  [WS];
    logic [WS-1:0]  el_row [WS];
    logic [WS-1:0]  el_vld, eq_q, he_q;
    logic           force_eq = 1'b0;
    logic [WS-1:0]  force_val = '0;
    assign is_equal_vec = force_eq ? force_val : eq_q;
    assign has_edge_vec = he_q;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            el_vld <= '0;
            eq_q   <= '0;
            he_q   <= '0;
            for (int i = 0; i < WS; i++) begin
                el_id[i]  <= '0;
                el_row[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WS; i++) begin
                eq_q[i] <= el_vld[i] && (el_id[i] == edge_in);
                he_q[i] <= el_vld[i] && (el_id[i] == edge_in) && el_row[i][edge_addr];
                if (data_rdy_in[i]) begin
                    el_id[i]  <= edge_in;
                    el_vld[i] <= 1'b1;
                    el_row[i] <= '0;
                end
                if (edge_rdy && el_vld[i] && el_id[i] == edge_in) el_row[i][edge_addr] <= 1'b1;
            end
        end
    end

    // scoreboard bookkeeping
    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int             cap_alloc, cap_write, cap_res, cap_busy;
    logic           cap_res_edge;
    logic [AW-1:0]  cap_wr_addr, cap_res_addr;
    logic [IDW-1:0] cap_wr_id;
    logic [IDW-1:0] cap_ids[$];
    logic [WS-1:0]  cap_vecs[$];

    task automatic clear_caps();
        cap_alloc = 0; cap_write = 0; cap_res = 0; cap_busy = 0;
        cap_res_edge = 1'b0; cap_wr_addr = '0; cap_wr_id = '0; cap_res_addr = '0;
        cap_ids.delete();
        cap_vecs.delete();
    endtask

    task automatic sample();
        if (data_rdy_in != '0) begin
            cap_alloc++;
            cap_ids.push_back(edge_in);
            cap_vecs.push_back(data_rdy_in);
        end
        if (edge_rdy) begin
            cap_write++;
            cap_wr_addr = edge_addr;
            cap_wr_id   = edge_in;
        end
        if (result_valid) begin
            cap_res++;
            cap_res_edge = result_edge;
            cap_res_addr = edge_addr;
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 20 && !edge_ready; n++) step();
    endtask

    // driver: one transaction from accept until the FSM is back in IDLE
    task automatic run_txn(input bit is_q, input logic [IDW-1:0] s, input logic [IDW-1:0] d);
        clear_caps();
        wait_idle();
        if (is_q) begin qry_valid = 1'b1; qry_src = s; qry_dst = d; end
        else      begin edge_valid = 1'b1; edge_src = s; edge_dst = d; end
        step();
        edge_valid = 1'b0;
        qry_valid  = 1'b0;
        while (!edge_ready && cap_busy < 20) begin
            sample();
            if (is_q && cap_busy == 1) begin
                force_eq = force_eq;
            end
            step();
            cap_busy++;
        end
    endtask

    typedef struct {
        bit             is_q;
        logic [IDW-1:0] s, d;
        int             n_alloc, n_write, n_res;
        bit             res_edge;
        int             busy, fill;
        bit             ovf;
    } vec_t;

    vec_t vecs[15];
    int   found;

    initial begin
        vecs[0]  = '{1'b0, 11'd5,  11'd9,   2, 1, 0, 1'b0, 5 + DX, 2, 1'b0};
        vecs[1]  = '{1'b1, 11'd5,  11'd9,   0, 0, 1, 1'b1, 6,      2, 1'b0};
        vecs[2]  = '{1'b1, 11'd9,  11'd5,   0, 0, 1, 1'b0, 6,      2, 1'b0};
        vecs[3]  = '{1'b1, 11'd5,  11'd7,   0, 0, 1, 1'b0, 3,      2, 1'b0};
        vecs[4]  = '{1'b0, 11'd7,  11'd7,   1, 1, 0, 1'b0, 5 + DX, 3, 1'b0};
        vecs[5]  = '{1'b1, 11'd7,  11'd7,   0, 0, 1, 1'b1, 6,      3, 1'b0};
        vecs[6]  = '{1'b0, 11'd9,  11'd5,   0, 1, 0, 1'b0, 5 + DX, 3, 1'b0};
        vecs[7]  = '{1'b1, 11'd9,  11'd5,   0, 0, 1, 1'b1, 6,      3, 1'b0};
        vecs[8]  = '{1'b0, 11'd1,  11'd5,   1, 1, 0, 1'b0, 5 + DX, 4, 1'b0};
        vecs[9]  = '{1'b0, 11'd1,  11'd100, 0, 0, 0, 1'b0, 2,      4, 1'b1};
        vecs[10] = '{1'b1, 11'd1,  11'd5,   0, 0, 1, 1'b1, 6,      4, 1'b1};
        vecs[11] = '{1'b1, 11'd1,  11'd100, 0, 0, 1, 1'b0, 3,      4, 1'b1};
        vecs[12] = '{1'b0, 11'd5,  11'd1,   0, 1, 0, 1'b0, 5 + DX, 4, 1'b1};
        vecs[13] = '{1'b1, 11'd5,  11'd1,   0, 0, 1, 1'b1, 6,      4, 1'b1};
        vecs[14] = '{1'b1, 11'd50, 11'd9,   0, 0, 1, 1'b0, 5,      4, 1'b1};

        // reset state
        #12;
        check("rst_edge_ready", edge_ready, 0);
        check("rst_fill", fill_cnt, 0);
        check("rst_outputs", {result_valid, edge_rdy, data_rdy_in, edge_addr, edge_in}, 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("idle_ready", {edge_ready, qry_ready}, 2'b11);
        check("idle_flags", {overflow, multi_hit}, 0);

        for (int i = 0; i < 15; i++) begin
            run_txn(vecs[i].is_q, vecs[i].s, vecs[i].d);
            check($sformatf("v%0d_alloc", i), cap_alloc, vecs[i].n_alloc);
            check($sformatf("v%0d_write", i), cap_write, vecs[i].n_write);
            check($sformatf("v%0d_res", i), cap_res, vecs[i].n_res);
            check($sformatf("v%0d_busy", i), cap_busy, vecs[i].busy);
            check($sformatf("v%0d_fill", i), fill_cnt, vecs[i].fill);
            check($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
            check($sformatf("v%0d_mh", i), multi_hit, 0);
            if (vecs[i].is_q) check($sformatf("v%0d_redge", i), cap_res_edge, vecs[i].res_edge);
            if (i == 0) begin
                if (cap_ids.size() == 2) begin
                    check("ins0_alloc0_id", cap_ids[0], 9);
                    check("ins0_alloc0_vec", cap_vecs[0], 4'b0001);
                    check("ins0_alloc1_id", cap_ids[1], 5);
                    check("ins0_alloc1_vec", cap_vecs[1], 4'b0010);
                end
                check("ins0_wr_addr", cap_wr_addr, 0);
                check("ins0_wr_id", cap_wr_id, 5);
            end
        end

`ifdef MATRIX_SEQ_DEDUP_EN
        // repeat insert of an existing edge is counted, not written
        run_txn(1'b0, 11'd5, 11'd9);
        check("dedup_write", cap_write, 0);
        check("dedup_cnt", dup_cnt, 1);
        check("dedup_busy", cap_busy, 7);
`endif

        // forced double compare hit: lowest slot (1) must be chosen
        clear_caps();
        wait_idle();
        qry_valid = 1'b1; qry_src = 11'd5; qry_dst = 11'd9;
        step();
        qry_valid = 1'b0;
        step();
        force_eq = 1'b1; force_val = 4'b0110;
        step();
        force_eq = 1'b0;
        for (int n = 0; n < 10 && !edge_ready; n++) begin sample(); step(); end
        check("mh_flag", multi_hit, 1);
        check("mh_res", cap_res, 1);
        check("mh_addr", cap_res_addr, 1);
        check("mh_redge", cap_res_edge, 0);

        // simultaneous insert and query: insert first, query waits for IDLE
        clear_caps();
        wait_idle();
        edge_valid = 1'b1; edge_src = 11'd9; edge_dst = 11'd7;
        qry_valid  = 1'b1; qry_src  = 11'd9; qry_dst  = 11'd7;
        #1;
        check("sim_edge_ready", edge_ready, 1);
        check("sim_qry_ready", qry_ready, 0);
        step();
        edge_valid = 1'b0;
        found = 0;
        for (int n = 0; n < 30 && found == 0; n++) begin
            logic acc;
            #1;
            acc = qry_ready && qry_valid;
            sample();
            step();
            if (acc) qry_valid = 1'b0;
            if (result_valid) begin
                found = 1;
                sample();
            end
        end
        qry_valid = 1'b0;
        check("sim_result_seen", found, 1);
        check("sim_write_before", cap_write, 1);
        check("sim_redge", cap_res_edge, 1);

        // reset asserted during WRITE
        clear_caps();
        wait_idle();
        edge_valid = 1'b1; edge_src = 11'd7; edge_dst = 11'd9;
        step();
        edge_valid = 1'b0;
        found = 0;
        for (int n = 0; n < 12 && found == 0; n++) begin
            if (edge_rdy) found = 1;
            else step();
        end
        check("rw_reached_write", found, 1);
        rst_n = 1'b0;
        #1;
        check("rw_edge_rdy", edge_rdy, 0);
        check("rw_ready", edge_ready, 0);
        check("rw_fill", fill_cnt, 0);
        check("rw_flags", {overflow, multi_hit}, 0);
`ifdef MATRIX_SEQ_DEDUP_EN
        check("rw_dup", dup_cnt, 0);
`endif
        clear_caps();
        for (int n = 0; n < 3; n++) begin sample(); step(); end
        check("rw_no_result", cap_res + cap_write, 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("rw_idle", {edge_ready, qry_ready}, 2'b11);
        check("rw_addr", edge_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
